ppu_write_scheduler: RTL and testbench

Sits between the Avalon-style CPU slave port and the PPU's three tables: attribute, sprite and color. It buffers CPU writes in a FIFO and commits them to the tables only during vertical blanking, so the sprite scan and pixel output never see a half-updated frame. A fence command groups writes so that each batch lands within a single blanking interval.

---
 rtl/ppu_pkg.sv | 49 ++++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/ppu_write_scheduler.sv | 153 +++++++++++++++
 tb/tb_ppu_write_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// ---------------------------------------------------------------------------
// ppu_pkg
// Shared types and constants for the PPU write scheduler.
//   tbl_sel_t  : table selector carried in bus address bits [9:8]
//   wq_entry_t : one write-queue entry (fence flag, table, entry, data)
//   state_t    : scheduler state (ACTIVE, DRAIN, FENCED)
//   sel_to_we  : table selector to one-hot table write enable
// ---------------------------------------------------------------------------
package ppu_pkg;

    // First scanline that counts as vertical blanking.
    localparam int VACTIVE_DEFAULT = 480;

    // Entry index that turns a CTRL-space write into a fence token.
    localparam logic [7:0] FENCE_ADDR = 8'hFF;

    typedef enum logic [1:0] {
        ATTR   = 2'b00,
        SPRITE = 2'b01,
        COLOR  = 2'b10,
        CTRL   = 2'b11
    } tbl_sel_t;

    typedef struct packed {
        logic        fence;
        tbl_sel_t    sel;
        logic [7:0]  addr;
        logic [31:0] data;
    } wq_entry_t;

    localparam int WQ_W = $bits(wq_entry_t);

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        DRAIN  = 2'd1,
        FENCED = 2'd2
    } state_t;

    // CTRL never reaches the tables, so it maps to no enable at all.
    function automatic logic [2:0] sel_to_we(input tbl_sel_t sel);
        case (sel)
            ATTR:    sel_to_we = 3'b001;
            SPRITE:  sel_to_we = 3'b010;
            COLOR:   sel_to_we = 3'b100;
            default: sel_to_we = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a registered occupancy count and show-ahead read
// (pop_data is the current head, valid whenever empty is low).
// Ports:
//   clk, reset     : clock, synchronous active-high reset (empties the FIFO)
//   push/push_data : write one entry; ignored while full
//   pop/pop_data   : drop the head entry; ignored while empty
//   full, empty    : occupancy flags decoded from the registered count
//   count          : number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; validity is tracked by count alone,
    // so clearing it would only add reset fan-out without changing behaviour.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are log2(DEPTH) bits wide, so they wrap on their own.
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ppu_write_scheduler.sv
// ---------------------------------------------------------------------------
// ppu_write_scheduler
// Queues CPU writes to the attribute / sprite / color tables and replays them
// only during vertical blanking. A fence token ends a batch: once it retires
// nothing more is committed until the next blanking interval.
// Ports:
//   clk, reset            : 50 MHz clock, synchronous active-high reset
//   writedata, write,
//   chipselect, address   : Avalon-style slave write port
//                           (address[9:8] = table, address[7:0] = entry,
//                            table 3 entry 0xFF = fence)
//   vcount                : current scanline
//   tbl_we/addr/data      : registered one-hot table write
//   fifo_full, pending    : queue full / queue not empty
//   frame_commit          : one-cycle pulse when a fence retires
//   overflow              : sticky, a write was dropped because the queue was full
//   drop_count            : saturating dropped-write counter, present only when
//                           PPU_WSCHED_DROPCNT_EN is defined
// ---------------------------------------------------------------------------
module ppu_write_scheduler
    import ppu_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int VACTIVE = VACTIVE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] writedata,
    input  logic        write,
    input  logic        chipselect,
    input  logic [15:0] address,
    input  logic [9:0]  vcount,
    output logic [2:0]  tbl_we,
    output logic [7:0]  tbl_addr,
    output logic [31:0] tbl_data,
    output logic        fifo_full,
    output logic        pending,
    output logic        frame_commit,
    output logic        overflow
`ifdef PPU_WSCHED_DROPCNT_EN
    ,
    output logic [15:0] drop_count
`endif
);

    localparam logic [9:0] VBLANK_LINE = 10'(VACTIVE);

    state_t                state;
    tbl_sel_t              sel;
    logic                  vblank;
    logic                  accept;
    logic                  is_fence;
    logic                  enq_req;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  empty;
    wq_entry_t             push_entry;
    wq_entry_t             head;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                  unused_bits;

    assign sel      = tbl_sel_t'(address[9:8]);
    assign vblank   = (vcount >= VBLANK_LINE);
    assign accept   = chipselect && write;
    assign is_fence = (sel == CTRL) && (address[7:0] == FENCE_ADDR);
    // Non-fence CTRL addresses are silently ignored: no enqueue, no overflow.
    assign enq_req  = accept && ((sel != CTRL) || is_fence);
    // fifo_full reflects the count at the start of the cycle, so a pop in the
    // same cycle does not rescue a write that arrives while full.
    assign push     = enq_req && !fifo_full;
    assign drop     = enq_req && fifo_full;
    assign pop      = (state == DRAIN) && vblank && !empty;
    assign pending  = !empty;

    // NOTE: every field gets a default before any conditional assignment so
    // this block can never infer a latch.
    always_comb begin
        push_entry       = '0;
        push_entry.fence = is_fence;
        push_entry.sel   = sel;
        push_entry.addr  = address[7:0];
        push_entry.data  = is_fence ? 32'h0 : writedata;
    end

    sync_fifo #(
        .WIDTH (WQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (empty),
        .count     (fifo_count)
    );

    // Upper address bits are outside this slave's decode; the count is only
    // needed inside the FIFO for its flags.
    assign unused_bits = ^{address[15:10], fifo_count};

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ACTIVE;
            tbl_we       <= '0;
            tbl_addr     <= '0;
            tbl_data     <= '0;
            frame_commit <= 1'b0;
            overflow     <= 1'b0;
`ifdef PPU_WSCHED_DROPCNT_EN
            drop_count   <= '0;
`endif
        end else begin
            tbl_we       <= '0;
            frame_commit <= 1'b0;

            if (drop) begin
                overflow <= 1'b1;
`ifdef PPU_WSCHED_DROPCNT_EN
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
`endif
            end

            case (state)
                ACTIVE: begin
                    if (vblank) state <= DRAIN;
                end
                DRAIN: begin
                    if (!vblank) begin
                        state <= ACTIVE;
                    end else if (pop) begin
                        if (head.fence) begin
                            frame_commit <= 1'b1;
                            state        <= FENCED;
                        end else begin
                            tbl_we   <= sel_to_we(head.sel);
                            tbl_addr <= head.addr;
                            tbl_data <= head.data;
                        end
                    end
                end
                FENCED: begin
                    if (!vblank) state <= ACTIVE;
                end
                default: state <= ACTIVE;
            endcase
        end
    end

endmodule

// File: tb/tb_ppu_write_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ppu_write_scheduler
// Directed bench for ppu_write_scheduler: deferred commit in vblank, bus to
// table latency, fence batching, overflow, reset mid-drain, CTRL decode.
// ---------------------------------------------------------------------------
module tb_ppu_write_scheduler;

    typedef struct {
        logic [2:0]  we;
        logic [7:0]  addr;
        logic [31:0] data;
    } tw_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] writedata;
    logic        write;
    logic        chipselect;
    logic [15:0] address;
    logic [9:0]  vcount;
    logic [2:0]  tbl_we;
    logic [7:0]  tbl_addr;
    logic [31:0] tbl_data;
    logic        fifo_full;
    logic        pending;
    logic        frame_commit;
    logic        overflow;
`ifdef PPU_WSCHED_DROPCNT_EN
    logic [15:0] drop_count;
`endif

    int  checks    = 0;
    int  errors    = 0;
    int  commits   = 0;
    int  multihot  = 0;
    tw_t log_q[$];

    always #10 clk = ~clk;

    ppu_write_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .writedata    (writedata),
        .write        (write),
        .chipselect   (chipselect),
        .address      (address),
        .vcount       (vcount),
        .tbl_we       (tbl_we),
        .tbl_addr     (tbl_addr),
        .tbl_data     (tbl_data),
        .fifo_full    (fifo_full),
        .pending      (pending),
        .frame_commit (frame_commit),
        .overflow     (overflow)
`ifdef PPU_WSCHED_DROPCNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and record what the DUT shows just after the edge.
    task automatic step();
        tw_t e;
        @(posedge clk);
        #1;
        if (tbl_we != 3'b000) begin
            if (!$onehot(tbl_we)) multihot++;
            e.we   = tbl_we;
            e.addr = tbl_addr;
            e.data = tbl_data;
            log_q.push_back(e);
        end
        if (frame_commit) commits++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        step();
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        writedata  = '0;
        write      = 1'b0;
        chipselect = 1'b0;
        address    = '0;
        vcount     = 10'd100;
        steps(3);

        // Reset state
        check("rst_we",       32'(tbl_we), 32'h0);
        check("rst_addr",     32'(tbl_addr), 32'h0);
        check("rst_data",     tbl_data, 32'h0);
        check("rst_full",     32'(fifo_full), 32'h0);
        check("rst_pending",  32'(pending), 32'h0);
        check("rst_commit",   32'(frame_commit), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        reset = 1'b0;
        step();

        // Write held through active video, committed in vblank
        log_q.delete();
        bus_write(16'h0003, 32'hA0000010);
        check("t1_pending", 32'(pending), 32'h1);
        steps(5);
        check("t1_no_write_active", 32'(log_q.size()), 32'h0);
        vcount = 10'd480;
        steps(4);
        check("t1_count", 32'(log_q.size()), 32'h1);
        if (log_q.size() == 1) begin
            check("t1_we",   32'(log_q[0].we), 32'h1);
            check("t1_addr", 32'(log_q[0].addr), 32'h03);
            check("t1_data", log_q[0].data, 32'hA0000010);
        end
        check("t1_we_idle", 32'(tbl_we), 32'h0);
        check("t1_pending_after", 32'(pending), 32'h0);

        // Two-cycle latency while draining an empty FIFO
        log_q.delete();
        bus_write(16'h0205, 32'h00FF00FF);
        check("t2_we_edge_n", 32'(tbl_we), 32'h0);
        step();
        check("t2_we_edge_n1", 32'(tbl_we), 32'h4);
        check("t2_addr", 32'(tbl_addr), 32'h05);
        check("t2_data", tbl_data, 32'h00FF00FF);
        step();
        check("t2_we_one_cycle", 32'(tbl_we), 32'h0);
        vcount = 10'd100;
        steps(3);

        // Fence splits a batch across two vblanks
        log_q.delete();
        commits = 0;
        bus_write(16'h0100, 32'h11111111);
        bus_write(16'h0101, 32'h22222222);
        bus_write(16'h03FF, 32'hDEADBEEF);
        bus_write(16'h0201, 32'h33333333);
        vcount = 10'd480;
        steps(8);
        check("t3_first_count", 32'(log_q.size()), 32'h2);
        if (log_q.size() >= 2) begin
            check("t3_w0_addr", 32'(log_q[0].addr), 32'h00);
            check("t3_w0_we",   32'(log_q[0].we), 32'h2);
            check("t3_w1_addr", 32'(log_q[1].addr), 32'h01);
            check("t3_w1_data", log_q[1].data, 32'h22222222);
        end
        check("t3_commit_once", 32'(commits), 32'h1);
        check("t3_held", 32'(pending), 32'h1);
        vcount = 10'd100;
        steps(3);
        check("t3_active_count", 32'(log_q.size()), 32'h2);
        vcount = 10'd480;
        steps(5);
        check("t3_second_count", 32'(log_q.size()), 32'h3);
        if (log_q.size() == 3) begin
            check("t3_w2_we",   32'(log_q[2].we), 32'h4);
            check("t3_w2_addr", 32'(log_q[2].addr), 32'h01);
            check("t3_w2_data", log_q[2].data, 32'h33333333);
        end
        check("t3_commit_total", 32'(commits), 32'h1);
        check("t3_pending_done", 32'(pending), 32'h0);
        vcount = 10'd100;
        steps(3);

        // Overflow: 17 writes into 16 entries
        log_q.delete();
        for (int i = 0; i < 16; i++) bus_write(16'(i), 32'(i) + 32'hC000_0000);
        check("t4_full", 32'(fifo_full), 32'h1);
        check("t4_no_overflow_yet", 32'(overflow), 32'h0);
        bus_write(16'h0000, 32'hBAD0BAD0);
        check("t4_overflow", 32'(overflow), 32'h1);
        check("t4_still_full", 32'(fifo_full), 32'h1);
`ifdef PPU_WSCHED_DROPCNT_EN
        check("t4_drop_count", 32'(drop_count), 32'h1);
`endif
        vcount = 10'd480;
        steps(25);
        check("t4_writes", 32'(log_q.size()), 32'd16);
        if (log_q.size() == 16) begin
            check("t4_first_data", log_q[0].data, 32'hC000_0000);
            check("t4_last_addr",  32'(log_q[15].addr), 32'h0F);
            check("t4_last_data",  log_q[15].data, 32'hC000_000F);
        end
        check("t4_empty", 32'(pending), 32'h0);
        check("t4_not_full", 32'(fifo_full), 32'h0);
        vcount = 10'd100;
        steps(2);

        // Reset after three pops discards the rest
        do_reset();
        step();
        check("t5_overflow_cleared", 32'(overflow), 32'h0);
`ifdef PPU_WSCHED_DROPCNT_EN
        check("t5_drop_cleared", 32'(drop_count), 32'h0);
`endif
        log_q.delete();
        for (int i = 0; i < 10; i++) bus_write(16'h0100 + 16'(i), 32'h5000_0000 + 32'(i));
        vcount = 10'd480;
        for (int i = 0; i < 12; i++) begin
            if (log_q.size() >= 3) break;
            step();
        end
        check("t5_three_pops", 32'(log_q.size()), 32'h3);
        reset = 1'b1;
        step();
        check("t5_rst_we",      32'(tbl_we), 32'h0);
        check("t5_rst_addr",    32'(tbl_addr), 32'h0);
        check("t5_rst_data",    tbl_data, 32'h0);
        check("t5_rst_pending", 32'(pending), 32'h0);
        reset = 1'b0;
        steps(10);
        check("t5_no_more_writes", 32'(log_q.size()), 32'h3);
        check("t5_pending", 32'(pending), 32'h0);
        vcount = 10'd100;
        steps(2);

        // CTRL address that is not the fence is ignored
        bus_write(16'h03F0, 32'h12345678);
        check("t6_pending", 32'(pending), 32'h0);
        check("t6_overflow", 32'(overflow), 32'h0);

        // Fence at the head when vblank begins retires with no table writes
        log_q.delete();
        commits = 0;
        bus_write(16'h03FF, 32'h0);
        check("t7_pending", 32'(pending), 32'h1);
        vcount = 10'd480;
        steps(4);
        check("t7_commit", 32'(commits), 32'h1);
        check("t7_no_writes", 32'(log_q.size()), 32'h0);
        check("t7_empty", 32'(pending), 32'h0);

        check("never_multihot", 32'(multihot), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
